// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared states, exception codes, ports and op encodings for the translation scheduler
package mmu_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_TLB_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_TLBR = 3'd1,
    EXC_PIF  = 3'd2,
    EXC_PIL  = 3'd3,
    EXC_PIS  = 3'd4,
    EXC_PPI  = 3'd5,
    EXC_PME  = 3'd6
  } exc_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  function automatic op_e op_of(input logic is_data, input logic is_store);
    if (!is_data) return OP_FETCH;
    return is_store ? OP_STORE : OP_LOAD;
  endfunction

  // Page-invalid exception flavour depends on the kind of access.
  function automatic exc_e page_inv_exc(input op_e op);
    case (op)
      OP_FETCH: return EXC_PIF;
      OP_STORE: return EXC_PIS;
      default:  return EXC_PIL;
    endcase
  endfunction

endpackage

// File: rtl/dmw_match.sv
// rtl/dmw_match.sv - combinational hit check and address/MAT mapping for one direct-map window
module dmw_match (
  input  logic [31:0] dmw,
  input  logic [31:0] vaddr,
  input  logic [1:0]  plv,
  output logic        hit,
  output logic [31:0] paddr,
  output logic [1:0]  mat
);

  assign hit   = (dmw[31:29] == vaddr[31:29]) && dmw[plv];
  assign paddr = {dmw[27:25], vaddr[28:0]};
  assign mat   = dmw[5:4];

endmodule

// File: rtl/mmu_trans_sched.sv
// rtl/mmu_trans_sched.sv - fetch/data translation scheduler sharing one DMW check and TLB search port
// MMU_TLB_EN enables the TLB search path; without it unmapped addresses pass straight through.
module mmu_trans_sched
  import mmu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_vaddr0,
  input  logic [31:0] req_vaddr1,
  input  logic        req_store,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_paddr,
  output logic [1:0]  resp_mat,
  output logic [2:0]  resp_exc,
  input  logic        flush,
  input  logic        csr_da,
  input  logic        csr_pg,
  input  logic [1:0]  csr_plv,
  input  logic [1:0]  csr_datm,
  input  logic [31:0] csr_dmw0,
  input  logic [31:0] csr_dmw1,
  input  logic [9:0]  csr_asid,
  output logic        tlb_s_valid,
  output logic [18:0] tlb_s_vppn,
  output logic        tlb_s_odd,
  output logic [9:0]  tlb_s_asid,
  input  logic        tlb_r_found,
  input  logic        tlb_r_v,
  input  logic        tlb_r_d,
  input  logic [19:0] tlb_r_ppn,
  input  logic [1:0]  tlb_r_mat,
  input  logic [1:0]  tlb_r_plv
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e        state, state_n;
  logic          port_q;
  logic          store_q;
  logic [31:0]   vaddr_q;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    grant;

  logic [31:0]   paddr_n;
  logic [1:0]    mat_n;
  exc_e          exc_n;
  logic          resp_load;
  logic          direct;
  logic          need_tlb;

  logic          dmw0_hit, dmw1_hit;
  logic [31:0]   dmw0_paddr, dmw1_paddr;
  logic [1:0]    dmw0_mat, dmw1_mat;

  dmw_match u_dmw0 (
    .dmw   (csr_dmw0),
    .vaddr (vaddr_q),
    .plv   (csr_plv),
    .hit   (dmw0_hit),
    .paddr (dmw0_paddr),
    .mat   (dmw0_mat)
  );

  dmw_match u_dmw1 (
    .dmw   (csr_dmw1),
    .vaddr (vaddr_q),
    .plv   (csr_plv),
    .hit   (dmw1_hit),
    .paddr (dmw1_paddr),
    .mat   (dmw1_mat)
  );

  // Data normally wins; fetch wins once it has watched STARVE_LIMIT data grants go by.
  always_comb begin
    grant = 2'b00;
    if (resetn && (state == S_IDLE) && !flush) begin
      if (req_valid[PORT_DATA] &&
          !(req_valid[PORT_FETCH] && (starve_cnt == SW'(STARVE_LIMIT))))
        grant = 2'b10;
      else if (req_valid[PORT_FETCH])
        grant = 2'b01;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = (state == S_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign direct     = csr_da && !csr_pg;
  assign need_tlb   = (state == S_CHECK) && !direct && !dmw0_hit && !dmw1_hit;

  always_comb begin
    state_n   = state;
    paddr_n   = resp_paddr;
    mat_n     = resp_mat;
    exc_n     = EXC_NONE;
    resp_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (|grant) state_n = S_CHECK;
      end
      S_CHECK: begin
        resp_load = 1'b1;
        state_n   = S_RESP;
        if (direct) begin
          paddr_n = vaddr_q;
          mat_n   = csr_datm;
        end else if (dmw0_hit) begin
          paddr_n = dmw0_paddr;
          mat_n   = dmw0_mat;
        end else if (dmw1_hit) begin
          paddr_n = dmw1_paddr;
          mat_n   = dmw1_mat;
        end else begin
`ifdef MMU_TLB_EN
          resp_load = 1'b0;
          state_n   = S_TLB_WAIT;
`else
          paddr_n = vaddr_q;
          mat_n   = csr_datm;
`endif
        end
      end
`ifdef MMU_TLB_EN
      S_TLB_WAIT: begin
        paddr_n   = {tlb_r_ppn, vaddr_q[11:0]};
        mat_n     = tlb_r_mat;
        resp_load = 1'b1;
        state_n   = S_RESP;
        if (!tlb_r_found)
          exc_n = EXC_TLBR;
        else if (!tlb_r_v)
          exc_n = page_inv_exc(op_of(port_q, store_q));
        else if (tlb_r_plv > csr_plv)
          exc_n = EXC_PPI;
        else if (store_q && !tlb_r_d)
          exc_n = EXC_PME;
      end
`endif
      S_RESP: begin
        if (resp_ready[port_q]) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Flush abandons whatever is in flight, including a TLB result arriving this cycle.
    if (flush) begin
      state_n   = S_IDLE;
      resp_load = 1'b0;
    end
  end

`ifdef MMU_TLB_EN
  assign tlb_s_valid = need_tlb;
  assign tlb_s_vppn  = vaddr_q[31:13];
  assign tlb_s_odd   = vaddr_q[12];
  assign tlb_s_asid  = csr_asid;
`else
  logic unused_tlb;
  assign unused_tlb  = ^{need_tlb, store_q, csr_asid, tlb_r_found, tlb_r_v, tlb_r_d,
                         tlb_r_ppn, tlb_r_mat, tlb_r_plv};
  assign tlb_s_valid = 1'b0;
  assign tlb_s_vppn  = '0;
  assign tlb_s_odd   = 1'b0;
  assign tlb_s_asid  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      port_q     <= 1'b0;
      store_q    <= 1'b0;
      vaddr_q    <= '0;
      starve_cnt <= '0;
      resp_paddr <= '0;
      resp_mat   <= '0;
      resp_exc   <= EXC_NONE;
    end else begin
      state <= state_n;
      if (|grant) begin
        port_q  <= grant[PORT_DATA];
        store_q <= grant[PORT_DATA] & req_store;
        vaddr_q <= grant[PORT_DATA] ? req_vaddr1 : req_vaddr0;
      end
      if (resp_load) begin
        resp_paddr <= paddr_n;
        resp_mat   <= mat_n;
        resp_exc   <= exc_n;
      end
      if (!req_valid[PORT_FETCH] || grant[PORT_FETCH])
        starve_cnt <= '0;
      else if (grant[PORT_DATA] && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_trans_sched.sv
// tb/tb_mmu_trans_sched.sv - directed self-checking bench for the translation scheduler
module tb_mmu_trans_sched;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_vaddr0, req_vaddr1, resp_paddr;
  logic        req_store, flush;
  logic [1:0]  resp_mat;
  logic [2:0]  resp_exc;
  logic        csr_da, csr_pg;
  logic [1:0]  csr_plv, csr_datm;
  logic [31:0] csr_dmw0, csr_dmw1;
  logic [9:0]  csr_asid;
  logic        tlb_s_valid, tlb_s_odd;
  logic [18:0] tlb_s_vppn;
  logic [9:0]  tlb_s_asid;
  logic        tlb_r_found, tlb_r_v, tlb_r_d;
  logic [19:0] tlb_r_ppn;
  logic [1:0]  tlb_r_mat, tlb_r_plv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmu_trans_sched #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr0(req_vaddr0), .req_vaddr1(req_vaddr1), .req_store(req_store),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_paddr(resp_paddr), .resp_mat(resp_mat), .resp_exc(resp_exc),
    .flush(flush),
    .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv), .csr_datm(csr_datm),
    .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1), .csr_asid(csr_asid),
    .tlb_s_valid(tlb_s_valid), .tlb_s_vppn(tlb_s_vppn), .tlb_s_odd(tlb_s_odd),
    .tlb_s_asid(tlb_s_asid),
    .tlb_r_found(tlb_r_found), .tlb_r_v(tlb_r_v), .tlb_r_d(tlb_r_d),
    .tlb_r_ppn(tlb_r_ppn), .tlb_r_mat(tlb_r_mat), .tlb_r_plv(tlb_r_plv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE, checks the grant, and leaves the DUT in CHECK.
  task automatic issue(input logic port, input logic [31:0] va, input logic st, input string tag);
    req_valid = port ? 2'b10 : 2'b01;
    if (port) req_vaddr1 = va; else req_vaddr0 = va;
    req_store = st;
    #1;
    check({tag, "_grant"}, 32'(req_ready), port ? 32'd2 : 32'd1);
    step();
    req_valid = 2'b00;
    req_store = 1'b0;
  endtask

  task automatic retire(input logic port, input string tag);
    resp_ready = port ? 2'b10 : 2'b01;
    step();
    resp_ready = 2'b00;
    check({tag, "_drop"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic expect_resp(input logic port, input logic [31:0] pa, input logic [1:0] mat,
                             input exc_e exc, input string tag);
    check({tag, "_valid"}, 32'(resp_valid), port ? 32'd2 : 32'd1);
    check({tag, "_paddr"}, resp_paddr, pa);
    check({tag, "_mat"},   32'(resp_mat), 32'(mat));
    check({tag, "_exc"},   32'(resp_exc), 32'(exc));
  endtask

  task automatic tlb_case(input logic port, input logic st, input exc_e exc, input string tag);
    issue(port, 32'h0040_3008, st, tag);
    step();
    check({tag, "_early"}, 32'(resp_valid), 32'd0);
    step();
    expect_resp(port, {tlb_r_ppn, 12'h008}, tlb_r_mat, exc, tag);
    retire(port, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    bit got;
    resetn = 1'b0; req_valid = 2'b11; req_vaddr0 = '0; req_vaddr1 = '0; req_store = 1'b0;
    resp_ready = 2'b00; flush = 1'b0;
    csr_da = 1'b1; csr_pg = 1'b0; csr_plv = 2'd0; csr_datm = 2'b01;
    csr_dmw0 = '0; csr_dmw1 = '0; csr_asid = '0;
    tlb_r_found = 1'b0; tlb_r_v = 1'b0; tlb_r_d = 1'b0; tlb_r_ppn = '0;
    tlb_r_mat = '0; tlb_r_plv = '0;
    step();
    step();
    check("rst_req_ready",  32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_paddr",      resp_paddr, 32'd0);
    check("rst_mat",        32'(resp_mat), 32'd0);
    check("rst_exc",        32'(resp_exc), 32'(EXC_NONE));
    check("rst_tlb_s",      32'(tlb_s_valid), 32'd0);
    resetn = 1'b1; req_valid = 2'b00;
    step();

    // Direct mode fetch with wrong-port accept and no grant while in RESP
    issue(1'b0, 32'h1C00_0000, 1'b0, "direct");
    check("direct_no_tlb", 32'(tlb_s_valid), 32'd0);
    check("direct_t1", 32'(resp_valid), 32'd0);
    step();
    expect_resp(1'b0, 32'h1C00_0000, 2'b01, EXC_NONE, "direct");
    req_valid = 2'b01; resp_ready = 2'b10;
    #1;
    check("resp_no_grant", 32'(req_ready), 32'd0);
    step();
    req_valid = 2'b00;
    check("wrong_port_hold", 32'(resp_valid), 32'd1);
    retire(1'b0, "direct");

    // DMW0 wins over an overlapping DMW1
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0;
    csr_dmw0 = 32'h9000_0011; csr_dmw1 = 32'h8A00_0021;
    issue(1'b1, 32'h9000_1234, 1'b0, "dmw0");
    step();
    expect_resp(1'b1, 32'h1000_1234, 2'b01, EXC_NONE, "dmw0");
    retire(1'b1, "dmw0");

    // DMW1 hit when DMW0 lacks the current PLV
    csr_plv = 2'd3; csr_dmw1 = 32'h8A00_0028;
    issue(1'b1, 32'h9000_1234, 1'b0, "dmw1");
    step();
    expect_resp(1'b1, 32'hB000_1234, 2'b10, EXC_NONE, "dmw1");
    retire(1'b1, "dmw1");

    // Unmapped store
    csr_plv = 2'd0; csr_dmw0 = '0; csr_dmw1 = '0; csr_asid = 10'h155;
    tlb_r_found = 1'b1; tlb_r_v = 1'b1; tlb_r_d = 1'b0; tlb_r_ppn = 20'h12345;
    tlb_r_mat = 2'b01; tlb_r_plv = 2'd0;
    issue(1'b1, 32'h0040_3008, 1'b1, "map");
`ifdef MMU_TLB_EN
    check("map_s_valid", 32'(tlb_s_valid), 32'd1);
    check("map_s_vppn",  32'(tlb_s_vppn), 32'h201);
    check("map_s_odd",   32'(tlb_s_odd), 32'd1);
    check("map_s_asid",  32'(tlb_s_asid), 32'h155);
    step();
    check("map_t2", 32'(resp_valid), 32'd0);
    step();
    expect_resp(1'b1, 32'h1234_5008, 2'b01, EXC_PME, "map");
    retire(1'b1, "map");

    tlb_r_found = 1'b0;
    tlb_case(1'b0, 1'b0, EXC_TLBR, "tlbr");
    tlb_r_found = 1'b1; tlb_r_v = 1'b0;
    tlb_case(1'b1, 1'b0, EXC_PIL, "pil");
    tlb_r_v = 1'b1; tlb_r_d = 1'b1; tlb_r_plv = 2'd2; csr_plv = 2'd1;
    tlb_case(1'b1, 1'b0, EXC_PPI, "ppi");
    tlb_r_plv = 2'd0; csr_plv = 2'd0;

    // Flush while the TLB result is arriving
    issue(1'b1, 32'h0040_3008, 1'b0, "fl_tlb");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_tlb_no_resp", 32'(resp_valid), 32'd0);
    issue(1'b1, 32'h0040_3008, 1'b0, "fl_tlb_next");
    step();
    step();
    check("fl_tlb_next_valid", 32'(resp_valid), 32'd2);
    retire(1'b1, "fl_tlb_next");
`else
    check("map_no_tlb", 32'(tlb_s_valid), 32'd0);
    step();
    expect_resp(1'b1, 32'h0040_3008, 2'b01, EXC_NONE, "map");
    retire(1'b1, "map");
`endif

    // Flush in IDLE blocks the grant; flush in CHECK kills the response
    csr_da = 1'b1; csr_pg = 1'b0;
    flush = 1'b1; req_valid = 2'b01;
    #1;
    check("fl_idle_block", 32'(req_ready), 32'd0);
    flush = 1'b0; req_valid = 2'b00;
    step();
    issue(1'b0, 32'h1C00_0040, 1'b0, "fl_chk");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_chk_no_resp", 32'(resp_valid), 32'd0);
    issue(1'b0, 32'h1C00_0080, 1'b0, "fl_chk_next");
    step();
    expect_resp(1'b0, 32'h1C00_0080, 2'b01, EXC_NONE, "fl_chk_next");
    retire(1'b0, "fl_chk_next");

    // Starvation: both ports always valid
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int n = 0; n < 10; n++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        if (req_ready != 2'b00) begin
          got = 1'b1;
          g = req_ready;
        end else begin
          step();
        end
      end
      if (!got) begin
        check("starve_timeout", 32'd0, 32'd1);
      end else begin
        check($sformatf("starve_grant%0d", n), 32'(g), (n % 5 == 4) ? 32'd1 : 32'd2);
        step();
      end
    end
    req_valid = 2'b00;
    step();
    step();
    step();
    resp_ready = 2'b00;
    check("final_idle", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
